mdu_issue_ctrl: RTL and testbench

//   Issue/hazard controller sitting directly upstream of the multiply/divide unit in the E stage.

---
 rtl/mdu_issue_ctrl.sv | 96 +++++++++
 tb/tb_mdu_issue_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mdu_issue_ctrl.sv
//==============================================================================
// Module : mdu_issue_ctrl
// Issue/hazard controller for the E-stage multiply/divide unit.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module mdu_issue_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_valid_i,
    input  logic        e_flush_i,
    input  logic [3:0]  e_mdu_op_i,
    input  logic        d_is_md_i,
    output logic        start_o,
    output logic [3:0]  mdu_op_o,
    output logic        busy_o,
    output logic        stall_o,
    output logic [31:0] issue_cnt_o,
    output logic        err_o
);

    localparam logic [3:0] C_MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] C_DIV_LOAD  = 4'(DIV_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] issue_cnt_q, issue_cnt_d;
    logic        err_q, err_d;

    logic        w_is_md_op;
    logic        w_is_long_op;
    logic        w_qual;
    logic        w_busy;
    logic        w_start;
    logic        w_is_md_long;
    state_e      w_state;

    assign w_is_md_op   = (e_mdu_op_i >= 4'd1) && (e_mdu_op_i <= 4'd8);
    assign w_is_long_op = (e_mdu_op_i >= 4'd1) && (e_mdu_op_i <= 4'd4);
    assign w_qual       = e_valid_i & ~e_flush_i & w_is_md_op;
    assign w_busy       = (cnt_q != 4'd0);
    assign w_state      = w_busy ? ST_BUSY : ST_IDLE;

    // Issue is suppressed while reset is held so the MDU never sees a stray start.
    assign w_start      = w_qual & ~w_busy & ~reset;
    assign w_is_md_long = w_start & w_is_long_op;

    always_comb begin
        cnt_d       = cnt_q;
        issue_cnt_d = issue_cnt_q + {31'd0, w_start};
        err_d       = err_q | (w_qual & w_busy);
        case (w_state)
            ST_IDLE: begin
                if (w_is_md_long) begin
                    cnt_d = (e_mdu_op_i <= 4'd2) ? C_MULT_LOAD : C_DIV_LOAD;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 4'd1;
            end
            default: begin
                cnt_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= 4'd0;
            issue_cnt_q <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            issue_cnt_q <= issue_cnt_d;
            err_q       <= err_d;
        end
    end

    assign start_o     = w_start;
    assign mdu_op_o    = w_start ? e_mdu_op_i : 4'b0000;
    assign busy_o      = w_busy;
    assign stall_o     = d_is_md_i & (w_busy | w_is_md_long) & ~reset;
    assign issue_cnt_o = issue_cnt_q;
    assign err_o       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_issue_ctrl.sv
//==============================================================================
// Module : tb_mdu_issue_ctrl
// Table-driven self-checking bench for mdu_issue_ctrl.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_mdu_issue_ctrl;

    logic        clk;
    logic        reset;
    logic        e_valid_i;
    logic        e_flush_i;
    logic [3:0]  e_mdu_op_i;
    logic        d_is_md_i;
    logic        start_o;
    logic [3:0]  mdu_op_o;
    logic        busy_o;
    logic        stall_o;
    logic [31:0] issue_cnt_o;
    logic        err_o;

    int checks;
    int failures;

    mdu_issue_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .e_valid_i   (e_valid_i),
        .e_flush_i   (e_flush_i),
        .e_mdu_op_i  (e_mdu_op_i),
        .d_is_md_i   (d_is_md_i),
        .start_o     (start_o),
        .mdu_op_o    (mdu_op_o),
        .busy_o      (busy_o),
        .stall_o     (stall_o),
        .issue_cnt_o (issue_cnt_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        flush;
        logic [3:0]  op;
        logic        dmd;
        logic        x_start;
        logic [3:0]  x_op;
        logic        x_busy;
        logic        x_stall;
        logic [31:0] x_icnt;
        logic        x_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic f, input logic [3:0] op, input logic d,
                                input logic s, input logic [3:0] xo, input logic b, input logic st,
                                input logic [31:0] ic, input logic e);
        vec_t r;
        r.valid = v; r.flush = f; r.op = op; r.dmd = d;
        r.x_start = s; r.x_op = xo; r.x_busy = b; r.x_stall = st; r.x_icnt = ic; r.x_err = e;
        return r;
    endfunction

    // Drive on the falling edge, compare 1 time unit later (well clear of the rising edge).
    task automatic drive(input logic v, input logic f, input logic [3:0] op, input logic d);
        @(negedge clk);
        e_valid_i  = v;
        e_flush_i  = f;
        e_mdu_op_i = op;
        d_is_md_i  = d;
        #1;
    endtask

    task automatic check_all(input string tag, input vec_t r);
        check({tag, ".start"}, {31'd0, start_o}, {31'd0, r.x_start});
        check({tag, ".mdu_op"}, {28'd0, mdu_op_o}, {28'd0, r.x_op});
        check({tag, ".busy"}, {31'd0, busy_o}, {31'd0, r.x_busy});
        check({tag, ".stall"}, {31'd0, stall_o}, {31'd0, r.x_stall});
        check({tag, ".issue_cnt"}, issue_cnt_o, r.x_icnt);
        check({tag, ".err"}, {31'd0, err_o}, {31'd0, r.x_err});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset      = 1'b1;
        e_valid_i  = 1'b0;
        e_flush_i  = 1'b0;
        e_mdu_op_i = 4'd0;
        d_is_md_i  = 1'b0;

        // idle after reset
        vecs.push_back(mk(0,0,4'd0,0, 0,4'd0,0,0, 32'd0,0));
        // MULT issue, then busy for 4 cycles (stall shown with d_is_md in one), then idle
        vecs.push_back(mk(1,0,4'd1,0, 1,4'd1,0,0, 32'd0,0));
        vecs.push_back(mk(0,0,4'd0,0, 0,4'd0,1,0, 32'd1,0));
        vecs.push_back(mk(0,0,4'd0,1, 0,4'd0,1,1, 32'd1,0));
        vecs.push_back(mk(0,0,4'd0,0, 0,4'd0,1,0, 32'd1,0));
        vecs.push_back(mk(0,0,4'd0,0, 0,4'd0,1,0, 32'd1,0));
        vecs.push_back(mk(0,0,4'd0,0, 0,4'd0,0,0, 32'd1,0));
        // MFLO while idle: starts, no busy, no stall
        vecs.push_back(mk(1,0,4'd6,1, 1,4'd6,0,0, 32'd1,0));
        // flushed DIV: nothing happens
        vecs.push_back(mk(1,1,4'd3,1, 0,4'd0,0,0, 32'd2,0));
        // non-MD op code 9
        vecs.push_back(mk(1,0,4'd9,0, 0,4'd0,0,0, 32'd2,0));
        // DIVU with d_is_md held: stall in issue cycle + 9 more, drops on 11th
        vecs.push_back(mk(1,0,4'd4,1, 1,4'd4,0,1, 32'd2,0));
        for (int i = 0; i < 9; i++)
            vecs.push_back(mk(0,0,4'd0,1, 0,4'd0,1,1, 32'd3,0));
        vecs.push_back(mk(0,0,4'd0,1, 0,4'd0,0,0, 32'd3,0));
        // MTHI, d_is_md low
        vecs.push_back(mk(1,0,4'd7,0, 1,4'd7,0,0, 32'd3,0));
        vecs.push_back(mk(0,0,4'd0,0, 0,4'd0,0,0, 32'd4,0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].valid, vecs[i].flush, vecs[i].op, vecs[i].dmd);
            check_all($sformatf("vec%0d", i), vecs[i]);
        end

        // Protocol error: op 1 forced into E while cnt==3
        drive(1,0,4'd1,0); check_all("err.issue", mk(0,0,0,0, 1,4'd1,0,0, 32'd4,0));
        drive(0,0,4'd0,0); check_all("err.cnt4",  mk(0,0,0,0, 0,4'd0,1,0, 32'd5,0));
        drive(1,0,4'd1,0); check_all("err.force", mk(0,0,0,0, 0,4'd0,1,0, 32'd5,0));
        drive(0,0,4'd0,0); check_all("err.cnt2",  mk(0,0,0,0, 0,4'd0,1,0, 32'd5,1));
        drive(0,0,4'd0,0); check_all("err.cnt1",  mk(0,0,0,0, 0,4'd0,1,0, 32'd5,1));
        drive(0,0,4'd0,0); check_all("err.done",  mk(0,0,0,0, 0,4'd0,0,0, 32'd5,1));

        // Reset in the middle of a DIV (at cnt==5)
        drive(1,0,4'd3,0); check_all("rst.issue", mk(0,0,0,0, 1,4'd3,0,0, 32'd5,1));
        repeat (4) begin
            drive(0,0,4'd0,0);
            check("rst.busy", {31'd0, busy_o}, 32'd1);
        end
        @(negedge clk);
        reset = 1'b1;
        e_valid_i = 1'b1; e_flush_i = 1'b0; e_mdu_op_i = 4'd1; d_is_md_i = 1'b1;
        #1;
        check("rst.hold.start", {31'd0, start_o}, 32'd0);
        check("rst.hold.mdu_op", {28'd0, mdu_op_o}, 32'd0);
        check("rst.hold.stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        e_valid_i = 1'b1; e_mdu_op_i = 4'd9; d_is_md_i = 1'b1;
        #1;
        check_all("rst.after", mk(0,0,0,0, 0,4'd0,0,0, 32'd0,0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
